// File: rtl/el64_spi_pkg.sv
// Shared constants and types for the El-Barato-64 RAM-bridge SPI command master.
`timescale 1ns/1ps
package el64_spi_pkg;

    localparam logic [7:0] SPI_CMD_NOP        = 8'h00;
    localparam logic [7:0] SPI_CMD_WRITE      = 8'h01;
    localparam logic [7:0] SPI_CMD_READ_ADDR  = 8'h02;
    localparam logic [7:0] SPI_CMD_READ_DATA  = 8'h03;
    localparam logic [7:0] SPI_CMD_READ_READY = 8'h04;
    localparam logic [7:0] READY_OK           = 8'h01;

    typedef enum logic {OP_WRITE = 1'b0, OP_READ = 1'b1} cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WRITE, ST_RADDR, ST_POLL, ST_RDATA, ST_DONE
    } state_e;

    typedef enum logic [1:0] {PH_LEAD, PH_BYTE, PH_TRAIL} phase_e;

    typedef enum logic [1:0] {SH_IDLE, SH_LOW, SH_HIGH, SH_GAP} sh_state_e;

    // Index of the last byte in the frame a given state transmits.
    function automatic logic [2:0] frame_last(input state_e st);
        case (st)
            ST_WRITE: frame_last = 3'd5;
            ST_RADDR: frame_last = 3'd3;
            ST_POLL:  frame_last = 3'd1;
            ST_RDATA: frame_last = 3'd2;
            default:  frame_last = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input state_e st, input logic [2:0] idx,
                                              input logic [23:0] addr, input logic [15:0] wdata);
        frame_byte = SPI_CMD_NOP;
        case (st)
            ST_WRITE, ST_RADDR: begin
                case (idx)
                    3'd0:    frame_byte = (st == ST_WRITE) ? SPI_CMD_WRITE : SPI_CMD_READ_ADDR;
                    3'd1:    frame_byte = addr[23:16];
                    3'd2:    frame_byte = addr[15:8];
                    3'd3:    frame_byte = addr[7:0];
                    3'd4:    frame_byte = wdata[15:8];
                    3'd5:    frame_byte = wdata[7:0];
                    default: frame_byte = SPI_CMD_NOP;
                endcase
            end
            ST_POLL:  if (idx == 3'd0) frame_byte = SPI_CMD_READ_READY;
            ST_RDATA: if (idx == 3'd0) frame_byte = SPI_CMD_READ_DATA;
            default:  frame_byte = SPI_CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/spi_cmd_master_shifter.sv
// Mode-0 SPI byte engine: shifts one byte MSB first, samples MISO on SCK rise, then idles SCK low for the gap.
`timescale 1ns/1ps
module spi_byte_shifter
    import el64_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    sh_state_e   st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d, rx_q, rx_d;
    logic        sck_q, sck_d, mosi_q, mosi_d, done_q, done_d;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        rx_d   = rx_q;
        sck_d  = sck_q;
        mosi_d = mosi_q;
        done_d = 1'b0;
        case (st_q)
            SH_IDLE: if (start) begin
                sh_d   = tx_byte;
                mosi_d = tx_byte[7];
                cnt_d  = '0;
                bit_d  = '0;
                st_d   = SH_LOW;
            end
            SH_LOW: if (cnt_q == DIV_LAST) begin
                sck_d = 1'b1;
                rx_d  = {rx_q[6:0], miso};
                cnt_d = '0;
                st_d  = SH_HIGH;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            SH_HIGH: if (cnt_q == DIV_LAST) begin
                sck_d = 1'b0;
                cnt_d = '0;
                if (bit_q == 3'd7) begin
                    mosi_d = 1'b0;
                    st_d   = SH_GAP;
                end else begin
                    bit_d  = bit_q + 3'd1;
                    sh_d   = {sh_q[6:0], 1'b0};
                    mosi_d = sh_q[6];
                    st_d   = SH_LOW;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            SH_GAP: if (cnt_q == GAP_LAST) begin
                done_d = 1'b1;
                st_d   = SH_IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            default: st_d = SH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= SH_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            rx_q   <= '0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            rx_q   <= rx_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            done_q <= done_d;
        end
    end

    assign rx_byte = rx_q;
    assign done    = done_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
endmodule

// File: rtl/spi_cmd_master.sv
// Client-request to El-Barato-64 SPI frame sequencer (write, read-address, ready polling, read-data).
// Define SPI_POLL_TIMEOUT_EN to abort a read with rsp_err after MAX_POLLS not-ready polls.
`timescale 1ns/1ps
module spi_cmd_master
    import el64_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_POLLS  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SSEL
);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rsp_rdata_q, rsp_rdata_d;
    logic [7:0]  tx_q, tx_d, status_q, status_d, rx_byte;
    logic        ssel_q, ssel_d, start_q, start_d, byte_done;
    logic        rsp_valid_q, rsp_valid_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;
`ifdef SPI_POLL_TIMEOUT_EN
    localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS - 1);
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic        rsp_err_q, rsp_err_d;
`endif

    spi_byte_shifter #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) u_shifter (
        .clk(clk), .rst_n(rst_n), .start(start_q), .tx_byte(tx_q), .rx_byte(rx_byte),
        .done(byte_done), .sck(SCK), .mosi(MOSI), .miso(MISO)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rsp_rdata_d = rsp_rdata_q;
        tx_d        = tx_q;
        status_d    = status_q;
        ssel_d      = ssel_q;
        start_d     = 1'b0;
`ifdef SPI_POLL_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_ready_q) begin
                addr_d      = cmd_addr;
                wdata_d     = cmd_wdata;
                rsp_rdata_d = '0;
                state_d     = (cmd_op_e'(cmd_op) == OP_READ) ? ST_RADDR : ST_WRITE;
                ssel_d      = 1'b0;
                phase_d     = PH_LEAD;
                cnt_d       = '0;
`ifdef SPI_POLL_TIMEOUT_EN
                poll_cnt_d  = '0;
                rsp_err_d   = 1'b0;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                case (phase_q)
                    PH_LEAD: if (cnt_q == GAP_LAST) begin
                        phase_d = PH_BYTE;
                        idx_d   = '0;
                        start_d = 1'b1;
                        tx_d    = frame_byte(state_q, 3'd0, addr_q, wdata_q);
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    PH_BYTE: if (byte_done) begin
                        // Only the response positions of POLL and RDATA carry meaningful MISO data.
                        if (state_q == ST_POLL && idx_q == 3'd1)  status_d     = rx_byte;
                        if (state_q == ST_RDATA && idx_q == 3'd1) rbuf_d[15:8] = rx_byte;
                        if (state_q == ST_RDATA && idx_q == 3'd2) rbuf_d[7:0]  = rx_byte;
                        if (idx_q == frame_last(state_q)) begin
                            phase_d = PH_TRAIL;
                            ssel_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            start_d = 1'b1;
                            tx_d    = frame_byte(state_q, idx_q + 3'd1, addr_q, wdata_q);
                        end
                    end
                    default: if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        phase_d = PH_LEAD;
                        case (state_q)
                            ST_WRITE: state_d = ST_DONE;
                            ST_RADDR: begin
                                state_d = ST_POLL;
                                ssel_d  = 1'b0;
                            end
                            ST_POLL: if (status_q == READY_OK) begin
                                state_d = ST_RDATA;
                                ssel_d  = 1'b0;
`ifdef SPI_POLL_TIMEOUT_EN
                            end else if (poll_cnt_q == POLL_LAST) begin
                                state_d     = ST_DONE;
                                rsp_err_d   = 1'b1;
                                rsp_rdata_d = '0;
                            end else begin
                                poll_cnt_d = poll_cnt_q + 8'd1;
                                ssel_d     = 1'b0;
`else
                            end else begin
                                ssel_d = 1'b0;
`endif
                            end
                            default: begin
                                state_d     = ST_DONE;
                                rsp_rdata_d = rbuf_q;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                endcase
            end
        endcase
        rsp_valid_d = (state_d == ST_DONE);
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_LEAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rsp_rdata_q <= '0;
            tx_q        <= '0;
            status_q    <= '0;
            ssel_q      <= 1'b1;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rsp_rdata_q <= rsp_rdata_d;
            tx_q        <= tx_d;
            status_q    <= status_d;
            ssel_q      <= ssel_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SPI_POLL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign SSEL      = ssel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: SPI slave model, frame log, SCK timing monitor and directed/random command sequence.
`timescale 1ns/1ps
module tb_spi_cmd_master;
    localparam int CLK_DIV = 4;
    localparam int GAP     = 4;
    localparam int MAXP    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_op = 1'b0, MISO = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, busy, SCK, MOSI, SSEL;
    logic [15:0] rsp_rdata;

    spi_cmd_master #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .MAX_POLLS(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- SPI slave model ----------------
    logic [7:0]  s_rx = '0, s_tx = '0;
    int          s_bit = 0;
    logic [7:0]  frame_q[$];
    logic [7:0]  all_bytes[$];
    logic [7:0]  frame_cmds[$];
    int          frame_lens[$];
    logic [7:0]  status_fifo[$];
    logic [15:0] slave_data = '0;

    function automatic logic [7:0] resp_byte();
        int k = frame_q.size();
        if (k == 0) return 8'h00;
        if (frame_q[0] == 8'h04 && k == 1) begin
            if (status_fifo.size() > 0) return status_fifo.pop_front();
            return 8'hFF;
        end
        if (frame_q[0] == 8'h03 && k == 1) return slave_data[15:8];
        if (frame_q[0] == 8'h03 && k == 2) return slave_data[7:0];
        return 8'($urandom);
    endfunction

    always @(negedge SSEL) begin
        s_bit = 0; s_rx = '0; s_tx = '0; MISO = 1'b0;
        frame_q.delete();
    end
    always @(posedge SSEL) begin
        if (frame_q.size() > 0) begin
            frame_cmds.push_back(frame_q[0]);
            frame_lens.push_back(frame_q.size());
        end
    end
    always @(posedge SCK) if (SSEL === 1'b0) begin
        s_rx = {s_rx[6:0], MOSI};
        s_bit++;
        if (s_bit == 8) begin
            frame_q.push_back(s_rx);
            all_bytes.push_back(s_rx);
            s_bit = 0;
        end
    end
    always @(negedge SCK) if (SSEL === 1'b0) begin
        if (s_bit == 0) s_tx = resp_byte();
        else            s_tx = {s_tx[6:0], 1'b0};
        MISO = s_tx[7];
    end

    // ---------------- SCK / SSEL timing monitor ----------------
    int   sck_viol = 0, run = 0, rise_idx = 0, ssel_hi_run = 0;
    logic sck_p = 1'b0, ssel_p = 1'b1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (SCK !== sck_p) begin
                if (SCK === 1'b0 && run != CLK_DIV) sck_viol++;
                if (SCK === 1'b1) begin
                    if (rise_idx % 8 != 0 && run != CLK_DIV) sck_viol++;
                    if (rise_idx % 8 == 0 && rise_idx > 0 && run < GAP + CLK_DIV) sck_viol++;
                    rise_idx++;
                end
                run = 1;
            end else begin
                run++;
            end
            if (SSEL === 1'b1) begin
                if (SCK !== 1'b0) sck_viol++;
                rise_idx = 0;
            end
            if (SSEL === 1'b0 && ssel_p === 1'b1 && ssel_hi_run < GAP) sck_viol++;
            ssel_hi_run = (SSEL === 1'b1) ? ssel_hi_run + 1 : 0;
            sck_p  = SCK;
            ssel_p = SSEL;
        end else begin
            run = 0; rise_idx = 0; ssel_hi_run = GAP; sck_p = 1'b0; ssel_p = 1'b1;
        end
    end

    // ---------------- handshake / response monitors ----------------
    int          cyc = 0, acc_cyc = 0, acc_cnt = 0, rv_cyc = 0, rsp_cnt = 0;
    logic [15:0] last_rdata = '0;
    logic        last_err = 1'b0;
    always @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready === 1'b1) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        cyc++;
    end
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            rv_cyc     = cyc;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
    end

    // ---------------- reference model of expected frames ----------------
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_cmds[$];
    int         exp_lens[$];

    function automatic void model_write(input logic [23:0] a, input logic [15:0] d);
        exp_cmds.push_back(8'h01); exp_lens.push_back(6);
        exp_bytes.push_back(8'h01);
        exp_bytes.push_back(a[23:16]); exp_bytes.push_back(a[15:8]); exp_bytes.push_back(a[7:0]);
        exp_bytes.push_back(d[15:8]);  exp_bytes.push_back(d[7:0]);
    endfunction

    function automatic void model_read(input logic [23:0] a, input int polls, input bit with_data);
        exp_cmds.push_back(8'h02); exp_lens.push_back(4);
        exp_bytes.push_back(8'h02);
        exp_bytes.push_back(a[23:16]); exp_bytes.push_back(a[15:8]); exp_bytes.push_back(a[7:0]);
        for (int p = 0; p < polls; p++) begin
            exp_cmds.push_back(8'h04); exp_lens.push_back(2);
            exp_bytes.push_back(8'h04); exp_bytes.push_back(8'h00);
        end
        if (with_data) begin
            exp_cmds.push_back(8'h03); exp_lens.push_back(3);
            exp_bytes.push_back(8'h03); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
        end
    endfunction

    task automatic clear_logs();
        frame_cmds.delete(); frame_lens.delete(); all_bytes.delete();
        exp_cmds.delete(); exp_lens.delete(); exp_bytes.delete();
    endtask

    task automatic compare_log(input string tag);
        check({tag, " frames"}, 32'(frame_cmds.size()), 32'(exp_cmds.size()));
        for (int i = 0; i < frame_cmds.size() && i < exp_cmds.size(); i++) begin
            check({tag, " frame_cmd"}, 32'(frame_cmds[i]), 32'(exp_cmds[i]));
            check({tag, " frame_len"}, 32'(frame_lens[i]), 32'(exp_lens[i]));
        end
        check({tag, " nbytes"}, 32'(all_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < all_bytes.size() && i < exp_bytes.size(); i++)
            check({tag, " mosi_byte"}, 32'(all_bytes[i]), 32'(exp_bytes[i]));
        check({tag, " sck_timing"}, 32'(sck_viol), 32'd0);
        clear_logs();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic accept_cmd(input logic op, input logic [23:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("ready_wait_timeout", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_addr  = 24'($urandom);
        cmd_wdata = 16'($urandom);
    endtask

    task automatic wait_rsp(input int budget);
        int start_cnt = rsp_cnt;
        int n = 0;
        while (rsp_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rsp_cnt == start_cnt) check("rsp_wait_timeout", 32'(rsp_cnt), 32'(start_cnt + 1));
    endtask

    task automatic run_write(input string tag, input logic [23:0] a, input logic [15:0] d);
        int c0 = rsp_cnt;
        model_write(a, d);
        accept_cmd(1'b0, a, d);
        wait_rsp(6000);
        check({tag, " rsp_count"}, 32'(rsp_cnt), 32'(c0 + 1));
        check({tag, " rdata"}, 32'(last_rdata), 32'h0);
        check({tag, " err"}, 32'(last_err), 32'h0);
        compare_log(tag);
    endtask

    task automatic run_read(input string tag, input logic [23:0] a, input int not_ready,
                            input logic [15:0] data);
        int c0 = rsp_cnt;
        logic [7:0] v;
        status_fifo.delete();
        for (int i = 0; i < not_ready; i++) begin
            v = 8'($urandom);
            if (v == 8'h01) v = 8'hFF;
            status_fifo.push_back(v);
        end
        status_fifo.push_back(8'h01);
        slave_data = data;
        model_read(a, not_ready + 1, 1'b1);
        accept_cmd(1'b1, a, 16'($urandom));
        wait_rsp(8000);
        check({tag, " rsp_count"}, 32'(rsp_cnt), 32'(c0 + 1));
        check({tag, " rdata"}, 32'(last_rdata), 32'(data));
        check({tag, " err"}, 32'(last_err), 32'h0);
        compare_log(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a0, n;
        logic [23:0] ra;
        logic [15:0] rd;

        // Reset values, applied asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst SCK", 32'(SCK), 32'd0);
        check("rst SSEL", 32'(SSEL), 32'd1);
        check("rst MOSI", 32'(MOSI), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check("ready before first clk", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready after first clk", 32'(cmd_ready), 32'd1);
        check("idle busy", 32'(busy), 32'd0);
        clear_logs();

        // Directed write; busy/ready after acceptance and a one-cycle response pulse.
        c0 = rsp_cnt;
        model_write(24'h000001, 16'hDEAD);
        accept_cmd(1'b0, 24'h000001, 16'hDEAD);
        check("write busy after accept", 32'(busy), 32'd1);
        check("write ready after accept", 32'(cmd_ready), 32'd0);
        wait_rsp(6000);
        check("write rsp_count", 32'(rsp_cnt), 32'(c0 + 1));
        check("write rdata", 32'(last_rdata), 32'h0);
        check("write err", 32'(last_err), 32'h0);
        @(negedge clk);
        check("rsp_valid one cycle", 32'(rsp_valid), 32'd0);
        compare_log("write dead");

        // Directed read with two not-ready polls.
        c0 = rsp_cnt;
        status_fifo.delete();
        status_fifo.push_back(8'hFF); status_fifo.push_back(8'hFF); status_fifo.push_back(8'h01);
        slave_data = 16'hBEEF;
        model_read(24'h123456, 3, 1'b1);
        accept_cmd(1'b1, 24'h123456, 16'h5555);
        wait_rsp(8000);
        check("read rsp_count", 32'(rsp_cnt), 32'(c0 + 1));
        check("read rdata", 32'(last_rdata), 32'hBEEF);
        check("read err", 32'(last_err), 32'h0);
        repeat (5) @(negedge clk);
        check("read rdata held", 32'(rsp_rdata), 32'hBEEF);
        compare_log("read beef");

        // Randomized mix of writes and reads.
        for (int i = 0; i < 6; i++) begin
            ra = 24'($urandom);
            rd = 16'($urandom);
            if ($urandom_range(1, 0) == 0) run_write("rand write", ra, rd);
            else run_read("rand read", ra, int'($urandom_range(3, 0)), rd);
        end

        // Asynchronous reset during the third byte of a write.
        c0 = rsp_cnt;
        status_fifo.delete();
        accept_cmd(1'b0, 24'hA5A5A5, 16'h1234);
        n = 0;
        while (!(all_bytes.size() == 2 && s_bit >= 3) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) check("midreset wait_timeout", 32'(all_bytes.size()), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midreset SSEL", 32'(SSEL), 32'd1);
        check("midreset SCK", 32'(SCK), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset MOSI", 32'(MOSI), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset no rsp", 32'(rsp_cnt), 32'(c0));
        clear_logs();
        run_write("post-reset write", 24'h00BEEF, 16'hCAFE);

        // Back-to-back writes with cmd_valid held high throughout.
        c0 = rsp_cnt;
        a0 = acc_cnt;
        model_write(24'h111111, 16'hAAAA);
        model_write(24'h222222, 16'h5555);
        @(negedge clk);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_op = 1'b0; cmd_addr = 24'h111111; cmd_wdata = 16'hAAAA; cmd_valid = 1'b1;
        n = 0;
        while (acc_cnt == a0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_addr = 24'h222222; cmd_wdata = 16'h5555;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        check("b2b accepts", 32'(acc_cnt), 32'(a0 + 2));
        check("b2b first rsp", 32'(rsp_cnt), 32'(c0 + 1));
        check("b2b accept after rsp", 32'(acc_cyc), 32'(rv_cyc + 1));
        wait_rsp(6000);
        check("b2b second rsp", 32'(rsp_cnt), 32'(c0 + 2));
        repeat (10) @(negedge clk);
        check("b2b no extra accept", 32'(acc_cnt), 32'(a0 + 2));
        compare_log("b2b");

`ifdef SPI_POLL_TIMEOUT_EN
        // Slave never ready: exactly MAX_POLLS polls, then an error response.
        c0 = rsp_cnt;
        status_fifo.delete();
        slave_data = 16'h7777;
        model_read(24'h0F0F0F, MAXP, 1'b0);
        accept_cmd(1'b1, 24'h0F0F0F, 16'h0);
        wait_rsp(8000);
        check("timeout rsp_count", 32'(rsp_cnt), 32'(c0 + 1));
        check("timeout err", 32'(last_err), 32'd1);
        check("timeout rdata", 32'(last_rdata), 32'h0);
        compare_log("timeout");
        run_read("after timeout", 24'h00AA55, 1, 16'h3C3C);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
